fifo_rd_streamer: RTL and testbench

//   Read-side drain engine for the synchronous fifo. It drives fifo rd_en from fifo empty and

---
 rtl/fifo_rd_streamer.sv | 152 +++++++++++++++
 tb/tb_fifo_rd_streamer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_streamer.sv
// -----------------------------------------------------------------------------
// fifo_rd_streamer
//   Read-side drain engine for a synchronous fifo with a 1-cycle registered
//   dout. Issues fifo_rd_en whenever the 2-entry skid buffer can absorb the
//   beat, captures fifo_dout one cycle later, and presents the buffer head on a
//   valid/ready stream at up to 1 beat/clk.
//
// Ports
//   clk         in   single clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   flush       in   synchronous discard of buffered and in-flight beats
//   fifo_empty  in   fifo empty flag
//   fifo_dout   in   fifo read data, valid the cycle after rd_en is sampled
//   fifo_rd_en  out  fifo read strobe (combinational)
//   m_valid     out  stream valid
//   m_ready     in   stream ready
//   m_data      out  stream data (head of skid buffer)
//   beat_cnt    out  saturating pop counter (only with BEAT_CNT_EN)
//
// Build option
//   BEAT_CNT_EN  adds beat_cnt[15:0]: +1 per pop, saturates at 16'hFFFF,
//                cleared by reset and by flush.
//
// occ state  | meaning
// OCC_EMPTY  | skid buffer empty, m_valid low
// OCC_ONE    | one beat buffered (head only)
// OCC_TWO    | both entries full; never coexists with a beat in flight
// -----------------------------------------------------------------------------
module fifo_rd_streamer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef BEAT_CNT_EN
    ,
    output logic [15:0]           beat_cnt
`endif
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    occ_e                  occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic                  wptr_q, wptr_d;
    logic                  rptr_q, rptr_d;
    logic                  run_q, run_d;
    logic [DATA_WIDTH-1:0] buf_q [2];
    logic [DATA_WIDTH-1:0] buf_d [2];
    logic                  pop;
    logic                  cap;
    logic [2:0]            level;

    assign pop     = m_valid & m_ready;
    assign cap     = inflight_q;
    assign m_valid = (occ_q != OCC_EMPTY);
    assign m_data  = buf_q[rptr_q];

    // Occupancy the buffer will hold once the in-flight beat lands and the
    // current pop leaves; a new read is only safe if that leaves a free slot.
    assign level = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};

    // run_q holds rd_en off until the first clock after reset release.
    assign fifo_rd_en = run_q & ~fifo_empty & ~flush & (level < 3'd2);

    always_comb begin
        occ_d      = occ_q;
        inflight_d = fifo_rd_en;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        buf_d      = buf_q;
        run_d      = 1'b1;

        if (cap) begin
            buf_d[wptr_q] = fifo_dout;
            wptr_d        = ~wptr_q;
        end
        if (pop) begin
            rptr_d = ~rptr_q;
        end

        case ({cap, pop})
            2'b10:   occ_d = (occ_q == OCC_EMPTY) ? OCC_ONE : OCC_TWO;
            2'b01:   occ_d = (occ_q == OCC_TWO) ? OCC_ONE : OCC_EMPTY;
            default: occ_d = occ_q;
        endcase

        // Aligning rptr to the post-capture wptr leaves the buffer empty
        // whether or not a beat was captured on the flush edge.
        if (flush) begin
            occ_d      = OCC_EMPTY;
            inflight_d = 1'b0;
            rptr_d     = wptr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= OCC_EMPTY;
            inflight_q <= 1'b0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            run_q      <= 1'b0;
            buf_q      <= '{default: '0};
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            run_q      <= run_d;
            buf_q      <= buf_d;
        end
    end

`ifdef BEAT_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (flush) begin
            beat_cnt_d = 16'h0000;
        end else if (pop && (beat_cnt_q != 16'hFFFF)) begin
            beat_cnt_d = beat_cnt_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= 16'h0000;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`endif

    // The rd_en rule must never let a full buffer have another beat arriving.
    a_no_overfill : assert property (@(posedge clk) disable iff (!rst_n)
        !((occ_q == OCC_TWO) && inflight_q));

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_streamer
//   Directed bench for fifo_rd_streamer with a behavioural fifo (registered
//   dout) and a negedge monitor that logs every accepted stream beat.
// -----------------------------------------------------------------------------
module tb_fifo_rd_streamer;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
`ifdef BEAT_CNT_EN
    logic [15:0]   beat_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    fifo_rd_streamer #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
`ifdef BEAT_CNT_EN
        ,
        .beat_cnt   (beat_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural fifo: writes from the stimulus thread, reads on rd_en with
    // data appearing on fifo_dout one edge later.
    logic [DW-1:0] mem [0:1023];
    int            wr_ptr = 0;
    int            rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr[9:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Monitor
    logic [DW-1:0] rx [$];
    int            pop_cyc [$];
    int            cyc    = 0;
    int            rd_cnt = 0;
    int            viol   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_rd_en) rd_cnt = rd_cnt + 1;
        if (fifo_rd_en && fifo_empty) viol = viol + 1;
        if (m_valid && m_ready) begin
            rx.push_back(m_data);
            pop_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] b);
        mem[wr_ptr[9:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_rx(input int n, input int max_cyc, output bit ok);
        int i;
        i = 0;
        while ((rx.size() < n) && (i < max_cyc)) begin
            tick();
            i++;
        end
        ok = (rx.size() >= n);
    endtask

    task automatic test_reset();
        logic [DW-1:0] r [3];
        bit            ok;
        int            base;
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            r[i] = 8'($urandom_range(0, 255));
            push(r[i]);
        end
        tick();
        tick();
        @(negedge clk);
        total_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %0b expected 0", fifo_rd_en);
        else pass_cnt++;
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %0b expected 0", m_valid);
        else pass_cnt++;
        total_cnt++;
        if (m_data !== 8'h00) $display("FAIL reset_m_data: got %0h expected 00", m_data);
        else pass_cnt++;

        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL release_rd_en_pre_clk: got %0b expected 0", fifo_rd_en);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (fifo_rd_en !== 1'b1) $display("FAIL release_rd_en_first_clk: got %0b expected 1", fifo_rd_en);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL latency_valid_early: got %0b expected 0", m_valid);
        else pass_cnt++;
        tick();
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== r[0])
            $display("FAIL latency_first_beat: got valid=%0b data=%0h expected valid=1 data=%0h",
                     m_valid, m_data, r[0]);
        else pass_cnt++;

        base = rx.size();
        tick();
        m_ready = 1'b1;
        wait_rx(base + 3, 20, ok);
        total_cnt++;
        if (!ok) $display("FAIL reset_drain_timeout: got %0d beats expected 3", rx.size() - base);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (ok) begin
                total_cnt++;
                if (rx[base+i] !== r[i])
                    $display("FAIL reset_drain_data[%0d]: got %0h expected %0h", i, rx[base+i], r[i]);
                else pass_cnt++;
            end
        end
        tick();
        tick();
    endtask

    task automatic test_stream();
        logic [DW-1:0] e [8];
        bit            ok;
        int            base;
        base    = rx.size();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            e[i] = 8'($urandom_range(0, 255));
            push(e[i]);
        end
        wait_rx(base + 8, 40, ok);
        total_cnt++;
        if (!ok) $display("FAIL stream_timeout: got %0d beats expected 8", rx.size() - base);
        else pass_cnt++;
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                total_cnt++;
                if (rx[base+i] !== e[i])
                    $display("FAIL stream_data[%0d]: got %0h expected %0h", i, rx[base+i], e[i]);
                else pass_cnt++;
            end
            total_cnt++;
            if (pop_cyc[base+7] - pop_cyc[base] !== 7)
                $display("FAIL stream_back_to_back: got span %0d cycles expected 7",
                         pop_cyc[base+7] - pop_cyc[base]);
            else pass_cnt++;
        end
        tick();
        tick();
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0)
            $display("FAIL stream_idle: got valid=%0b rd_en=%0b expected 0 0", m_valid, fifo_rd_en);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] e [8];
        bit            ok;
        int            base;
        int            rc0;
        tick();
        m_ready = 1'b0;
        tick();
        base = rx.size();
        rc0  = rd_cnt;
        for (int i = 0; i < 8; i++) begin
            e[i] = 8'($urandom_range(0, 255));
            push(e[i]);
        end
        for (int i = 0; i < 8; i++) tick();
        @(negedge clk);
        #1;
        total_cnt++;
        if (rd_cnt - rc0 !== 2) $display("FAIL bp_rd_pulses: got %0d expected 2", rd_cnt - rc0);
        else pass_cnt++;
        total_cnt++;
        if (dut.occ_q !== 2'd2) $display("FAIL bp_occ: got %0d expected 2", dut.occ_q);
        else pass_cnt++;
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== e[0])
            $display("FAIL bp_hold: got valid=%0b data=%0h expected valid=1 data=%0h", m_valid, m_data, e[0]);
        else pass_cnt++;
        total_cnt++;
        if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_en_full: got %0b expected 0", fifo_rd_en);
        else pass_cnt++;

        tick();
        m_ready = 1'b1;
        wait_rx(base + 8, 40, ok);
        total_cnt++;
        if (!ok) $display("FAIL bp_timeout: got %0d beats expected 8", rx.size() - base);
        else pass_cnt++;
        if (ok) begin
            for (int i = 0; i < 8; i++) begin
                total_cnt++;
                if (rx[base+i] !== e[i])
                    $display("FAIL bp_data[%0d]: got %0h expected %0h", i, rx[base+i], e[i]);
                else pass_cnt++;
            end
        end
        tick();
        tick();
        tick();
        total_cnt++;
        if (rx.size() - base !== 8) $display("FAIL bp_count: got %0d beats expected 8", rx.size() - base);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [DW-1:0] e [$];
        logic [DW-1:0] b;
        int            base;
        int            npush;
        int            n;
        base  = rx.size();
        npush = 0;
        n     = 0;
        while ((rx.size() < base + 256) && (n < 3000)) begin
            tick();
            n++;
            m_ready = 1'($urandom_range(0, 1));
            if ((npush < 256) && ($urandom_range(0, 1) == 1)) begin
                b = 8'($urandom_range(0, 255));
                push(b);
                e.push_back(b);
                npush++;
            end
        end
        total_cnt++;
        if (rx.size() - base !== 256) $display("FAIL rand_count: got %0d beats expected 256", rx.size() - base);
        else pass_cnt++;
        if (rx.size() - base == 256) begin
            for (int i = 0; i < 256; i++) begin
                total_cnt++;
                if (rx[base+i] !== e[i])
                    $display("FAIL rand_data[%0d]: got %0h expected %0h", i, rx[base+i], e[i]);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (viol !== 0) $display("FAIL rand_rd_on_empty: got %0d expected 0", viol);
        else pass_cnt++;
        m_ready = 1'b1;
        tick();
        tick();
        tick();
    endtask

    task automatic test_flush();
        logic [DW-1:0] c [4];
        bit            ok;
        int            base;
        m_ready = 1'b0;
        tick();
        base = rx.size();
        for (int i = 0; i < 4; i++) begin
            c[i] = 8'($urandom_range(0, 255));
            push(c[i]);
        end
        tick();
        tick();
        total_cnt++;
        if (m_valid !== 1'b1 || dut.inflight_q !== 1'b1)
            $display("FAIL flush_precond: got valid=%0b inflight=%0b expected 1 1", m_valid, dut.inflight_q);
        else pass_cnt++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b0) $display("FAIL flush_valid: got %0b expected 0", m_valid);
        else pass_cnt++;
        tick();
        m_ready = 1'b1;
        wait_rx(base + 2, 20, ok);
        total_cnt++;
        if (!ok) $display("FAIL flush_timeout: got %0d beats expected 2", rx.size() - base);
        else pass_cnt++;
        if (ok) begin
            total_cnt++;
            if (rx[base] !== c[2]) $display("FAIL flush_next_beat: got %0h expected %0h", rx[base], c[2]);
            else pass_cnt++;
            total_cnt++;
            if (rx[base+1] !== c[3]) $display("FAIL flush_second_beat: got %0h expected %0h", rx[base+1], c[3]);
            else pass_cnt++;
        end
        tick();
        tick();
    endtask

`ifdef BEAT_CNT_EN
    task automatic test_beat_cnt();
        bit ok;
        int base;
        m_ready = 1'b0;
        flush   = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++;
        if (beat_cnt !== 16'h0000) $display("FAIL cnt_clear_initial: got %0h expected 0", beat_cnt);
        else pass_cnt++;
        base = rx.size();
        for (int i = 0; i < 10; i++) push(8'($urandom_range(0, 255)));
        m_ready = 1'b1;
        wait_rx(base + 10, 40, ok);
        tick();
        tick();
        total_cnt++;
        if (beat_cnt !== 16'd10) $display("FAIL cnt_ten: got %0d expected 10", beat_cnt);
        else pass_cnt++;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++;
        if (beat_cnt !== 16'h0000) $display("FAIL cnt_flush: got %0h expected 0", beat_cnt);
        else pass_cnt++;
        force dut.beat_cnt_q = 16'hFFFE;
        tick();
        release dut.beat_cnt_q;
        base = rx.size();
        for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
        wait_rx(base + 3, 20, ok);
        tick();
        tick();
        total_cnt++;
        if (beat_cnt !== 16'hFFFF) $display("FAIL cnt_saturate: got %0h expected ffff", beat_cnt);
        else pass_cnt++;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_random();
        test_flush();
`ifdef BEAT_CNT_EN
        test_beat_cnt();
`endif
        total_cnt++;
        if (viol !== 0) $display("FAIL rd_en_while_empty: got %0d expected 0", viol);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
